// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC, FSM encoding.
package ifu_pkg;

    localparam int unsigned IfuXlen    = 32;
    localparam logic [31:0] IfuResetPc = 32'h8000_0000;

    // Fetch FSM; one instruction in flight from request through commit.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StReq     = 3'd1,
        StResp    = 3'd2,
        StDeliver = 3'd3,
        StCommit  = 3'd4,
        StHalt    = 3'd5
    } ifu_state_e;

    // Word fetches only; any non-zero low PC bits are a fault.
    function automatic logic word_aligned(input logic [1:0] pc_lo);
        return pc_lo == 2'b00;
    endfunction

endpackage

// File: rtl/ifu.sv
// Non-pipelined instruction fetch unit: PC register, fetch FSM and registered outputs.
module ifu
    import ifu_pkg::*;
#(
    parameter int unsigned        XLEN     = IfuXlen,
    parameter logic [XLEN-1:0]    RESET_PC = XLEN'(IfuResetPc)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic            ifu_valid,
    input  logic            idu_ready,
    input  logic            wbu_valid,
    input  logic [XLEN-1:0] wbu_dnpc,
    output logic            fetch_fault
);

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic            req_valid_q, req_valid_d;
    logic            ifu_valid_q, ifu_valid_d;
    logic            fault_q, fault_d;

    // State and output registers; reset discards any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            req_valid_q <= 1'b0;
            ifu_valid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            req_valid_q <= req_valid_d;
            ifu_valid_q <= ifu_valid_d;
            fault_q     <= fault_d;
        end
    end

    // Next-state logic; inputs not relevant to the current state are ignored.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        req_valid_d = req_valid_q;
        ifu_valid_d = ifu_valid_q;
        fault_d     = fault_q;
        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                // First REQ cycle checks alignment, so a bad PC never reaches memory.
                if (!req_valid_q) begin
                    if (!word_aligned(pc_q[1:0])) begin
                        state_d = StHalt;
                        fault_d = 1'b1;
                    end else begin
                        req_valid_d = 1'b1;
                    end
                end else if (imem_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (imem_resp_valid) begin
                    if (imem_resp_err) begin
                        state_d = StHalt;
                        fault_d = 1'b1;
                    end else begin
                        inst_d      = imem_resp_data;
                        ifu_valid_d = 1'b1;
                        state_d     = StDeliver;
                    end
                end
            end
            StDeliver: begin
                if (idu_ready) begin
                    ifu_valid_d = 1'b0;
                    state_d     = StCommit;
                end
            end
            StCommit: begin
                // dnpc is taken verbatim, including wrap-around values.
                if (wbu_valid) begin
                    pc_d    = wbu_dnpc;
                    state_d = StReq;
                end
            end
            StHalt: begin
                req_valid_d = 1'b0;
                ifu_valid_d = 1'b0;
                fault_d     = 1'b1;
            end
            default: begin
                state_d     = StHalt;
                req_valid_d = 1'b0;
                ifu_valid_d = 1'b0;
                fault_d     = 1'b1;
            end
        endcase
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign inst           = inst_q;
    assign pc             = pc_q;
    assign ifu_valid      = ifu_valid_q;
    assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_ifu.sv
// Scoreboard bench for ifu: expected fetch addresses and decode packets are queued by the
// stimulus and checked by a monitor at each handshake.
module tb_ifu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        ifu_valid;
    logic        idu_ready;
    logic        wbu_valid;
    logic [31:0] wbu_dnpc;
    logic        fetch_fault;

    int n_vec = 0;
    int n_err = 0;
    int n_req_hs = 0;
    int n_dec_hs = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_dec_q[$];  // {inst, pc}

    ifu dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .inst            (inst),
        .pc              (pc),
        .ifu_valid       (ifu_valid),
        .idu_ready       (idu_ready),
        .wbu_valid       (wbu_valid),
        .wbu_dnpc        (wbu_dnpc),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare every handshake against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (imem_req_valid && imem_req_ready) begin
                n_req_hs++;
                n_vec++;
                if (exp_addr_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_req: got addr 0x%08h, expected no request",
                             imem_req_addr);
                end else begin
                    logic [31:0] ea;
                    ea = exp_addr_q.pop_front();
                    if (imem_req_addr !== ea) begin
                        n_err++;
                        $display("FAIL req_addr: got 0x%08h, expected 0x%08h", imem_req_addr, ea);
                    end
                end
            end
            if (ifu_valid && idu_ready) begin
                n_dec_hs++;
                n_vec++;
                if (exp_dec_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_dec: got inst 0x%08h, expected no delivery", inst);
                end else begin
                    logic [63:0] ed;
                    ed = exp_dec_q.pop_front();
                    if ({inst, pc} !== ed) begin
                        n_err++;
                        $display("FAIL dec_pkt: got inst/pc 0x%08h/0x%08h, expected 0x%08h/0x%08h",
                                 inst, pc, ed[63:32], ed[31:0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, "_req_addr"},  imem_req_addr,       32'h8000_0000);
        chk({tag, "_inst"},      inst,                32'd0);
        chk({tag, "_pc"},        pc,                  32'h8000_0000);
        chk({tag, "_ifu_valid"}, 32'(ifu_valid),      32'd0);
        chk({tag, "_fault"},     32'(fetch_fault),    32'd0);
    endtask

    // Wait (bounded) for a request, optionally stall it, then accept it.
    task automatic req_phase(input logic [31:0] addr, input int stall);
        int waited;
        waited = 0;
        exp_addr_q.push_back(addr);
        while (!imem_req_valid && waited < 10) begin
            tick();
            waited++;
        end
        if (!imem_req_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL req_timeout: got no request, expected addr 0x%08h", addr);
            void'(exp_addr_q.pop_back());
            return;
        end
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
            chk("req_hold_addr",  imem_req_addr,       addr);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("req_drop", 32'(imem_req_valid), 32'd0);
    endtask

    // Return a response after 'delay' idle cycles, pulsing wbu_valid meanwhile.
    task automatic resp_phase(input logic [31:0] data, input logic err,
                              input logic [31:0] exp_pc, input int delay);
        for (int i = 0; i < delay; i++) begin
            wbu_valid = 1'b1;
            wbu_dnpc  = 32'h9000_0000;
            tick();
        end
        wbu_valid       = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        imem_resp_err   = err;
        if (!err) exp_dec_q.push_back({data, exp_pc});
        tick();
        imem_resp_valid = 1'b0;
        imem_resp_err   = 1'b0;
        if (!err) begin
            chk("deliver_valid", 32'(ifu_valid), 32'd1);
            chk("deliver_inst",  inst,           data);
            chk("deliver_pc",    pc,             exp_pc);
        end
    endtask

    // Hold decode off for 'stall' cycles (with stray commits), then accept.
    task automatic dec_phase(input int stall, input logic [31:0] exp_inst,
                             input logic [31:0] exp_pc);
        for (int i = 0; i < stall; i++) begin
            wbu_valid = 1'b1;
            wbu_dnpc  = 32'h9000_0004;
            tick();
            chk("dec_hold_valid", 32'(ifu_valid), 32'd1);
            chk("dec_hold_inst",  inst,           exp_inst);
            chk("dec_hold_pc",    pc,             exp_pc);
        end
        idu_ready = 1'b1;
        tick();
        idu_ready = 1'b0;
        wbu_valid = 1'b0;
        chk("dec_drop", 32'(ifu_valid), 32'd0);
        chk("dec_pc_kept", pc, exp_pc);
    endtask

    task automatic commit(input logic [31:0] dnpc);
        wbu_valid = 1'b1;
        wbu_dnpc  = dnpc;
        tick();
        wbu_valid = 1'b0;
        chk("commit_pc", pc, dnpc);
    endtask

    initial begin
        int lat;
        int req0, dec0;
        rst_n           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_resp_err   = 1'b0;
        idu_ready       = 1'b0;
        wbu_valid       = 1'b0;
        wbu_dnpc        = '0;
        tick();
        tick();
        chk_reset_outputs("por");
        rst_n = 1'b1;

        // Request appears on the second edge after release.
        lat = 0;
        while (!imem_req_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("first_req_latency", 32'(lat), 32'd2);

        // T1: reset while waiting for a response.
        req_phase(32'h8000_0000, 0);
        rst_n = 1'b0;
        #2;
        chk_reset_outputs("mid_resp");
        tick();
        rst_n           = 1'b1;
        imem_resp_valid = 1'b1;  // late response from the aborted fetch
        imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        imem_resp_valid = 1'b0;
        chk("late_resp_inst",  inst,           32'd0);
        chk("late_resp_valid", 32'(ifu_valid), 32'd0);

        // T2: basic fetch.
        req_phase(32'h8000_0000, 0);
        resp_phase(32'h0010_0093, 1'b0, 32'h8000_0000, 0);
        dec_phase(0, 32'h0010_0093, 32'h8000_0000);

        // T6: stray response during commit wait.
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        imem_resp_valid = 1'b0;
        chk("stray_inst",  inst,           32'h0010_0093);
        chk("stray_valid", 32'(ifu_valid), 32'd0);

        // T4 commit, then T3 backpressure with stray commits in RESP/DELIVER.
        commit(32'h8000_0010);
        req0 = n_req_hs;
        dec0 = n_dec_hs;
        req_phase(32'h8000_0010, 4);
        resp_phase(32'h0020_0113, 1'b0, 32'h8000_0010, 2);
        dec_phase(3, 32'h0020_0113, 32'h8000_0010);
        chk("bp_one_req", 32'(n_req_hs - req0), 32'd1);
        chk("bp_one_dec", 32'(n_dec_hs - dec0), 32'd1);

        // PC wrap taken verbatim.
        commit(32'hFFFF_FFFC);
        req_phase(32'hFFFF_FFFC, 1);
        resp_phase(32'h0000_0013, 1'b0, 32'hFFFF_FFFC, 0);
        dec_phase(0, 32'h0000_0013, 32'hFFFF_FFFC);
        commit(32'h0000_0000);

        // T5b: access fault halts fetch.
        req_phase(32'h0000_0000, 0);
        resp_phase(32'h1234_5678, 1'b1, 32'h0000_0000, 0);
        chk("err_fault", 32'(fetch_fault), 32'd1);
        imem_req_ready = 1'b1;
        idu_ready      = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("err_halt_valid", 32'(ifu_valid),      32'd0);
        chk("err_halt_req",   32'(imem_req_valid), 32'd0);
        chk("err_halt_fault", 32'(fetch_fault),    32'd1);
        imem_req_ready = 1'b0;
        idu_ready      = 1'b0;

        // T5a: misaligned dnpc faults without issuing a request.
        rst_n = 1'b0;
        tick();
        chk("rst2_fault", 32'(fetch_fault), 32'd0);
        rst_n = 1'b1;
        req_phase(32'h8000_0000, 0);
        resp_phase(32'h0030_0193, 1'b0, 32'h8000_0000, 0);
        dec_phase(0, 32'h0030_0193, 32'h8000_0000);
        commit(32'h8000_0012);
        imem_req_ready = 1'b1;
        tick();
        chk("misalign_fault", 32'(fetch_fault), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        chk("misalign_no_req", 32'(imem_req_valid), 32'd0);
        chk("misalign_valid",  32'(ifu_valid),      32'd0);
        imem_req_ready = 1'b0;

        chk("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
        chk("dec_q_drained",  32'(exp_dec_q.size()),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
